hazard_ctrl: RTL and testbench

Central stall/forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W). Takes register fields and Tuse/Tnew timing codes from the D-stage decoder. Keeps its own scoreboard of in-flight destination registers for E, M and W. Drives the pipeline stall signal, the bypass-mux selects for the D, E and M stages, and a stall-cycle performance counter.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/hz_match.sv | 22 ++
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller: timing codes,
// bypass-mux encodings and the in-flight instruction record.
package mips_pkg;

  localparam int TW = 2;

  // D-stage bypass select
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  // E-stage bypass select
  localparam logic [1:0] FWD_E_REG = 2'd0;
  localparam logic [1:0] FWD_E_M   = 2'd1;
  localparam logic [1:0] FWD_E_W   = 2'd2;

  localparam logic [TW-1:0] TUSE_NONE = TW'(3);
  localparam logic [TW-1:0] TNEW_LINK = TW'(0);
  localparam logic [TW-1:0] TNEW_ALU  = TW'(1);
  localparam logic [TW-1:0] TNEW_LOAD = TW'(2);

  typedef struct packed {
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    a3;
    logic          we;
    logic [TW-1:0] tnew;
  } hz_rec_t;

  localparam hz_rec_t HZ_BUBBLE = '0;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

endpackage

// File: rtl/hz_match.sv
// Compares one scoreboard record against one source register: does the
// record produce that register, is its value ready, and must D wait for it.
module hz_match
  import mips_pkg::*;
(
  input  hz_rec_t       rec_i,
  input  logic [4:0]    reg_i,
  input  logic [TW-1:0] tuse_i,
  output logic          live_o,
  output logic          ready_o,
  output logic          stall_term_o
);

  logic unused_fields;
  assign unused_fields = ^{rec_i.rs, rec_i.rt};

  // $0 is hardwired, so it never creates a dependency
  assign live_o       = rec_i.we && (rec_i.a3 == reg_i) && (reg_i != 5'd0);
  assign ready_o      = live_o && (rec_i.tnew == '0);
  assign stall_term_o = live_o && (rec_i.tnew > tuse_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forwarding controller for the 5-stage pipeline. Tracks the E, M and
// W destination records itself and derives stall and bypass selects from them.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int TW    = mips_pkg::TW,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic [TW-1:0]    tuse_rs_D,
  input  logic [TW-1:0]    tuse_rt_D,
  input  logic [4:0]       a3_D,
  input  logic             we_D,
  input  logic [TW-1:0]    tnew_D,
  output logic             stall,
  output logic [1:0]       fwd_rs_D,
  output logic [1:0]       fwd_rt_D,
  output logic [1:0]       fwd_rs_E,
  output logic [1:0]       fwd_rt_E,
  output logic             fwd_rt_M,
  output logic [CNT_W-1:0] stall_cnt
);

  hz_rec_t          e_q, m_q, w_q;
  hz_rec_t          e_d, m_d, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [1:0] d_sel(input logic e_rdy, input logic m_rdy,
                                       input logic w_live);
    if (e_rdy)       return FWD_E;
    else if (m_rdy)  return FWD_M;
    else if (w_live) return FWD_W;
    else             return FWD_GRF;
  endfunction

  function automatic logic [1:0] e_sel(input logic m_rdy, input logic w_live);
    if (m_rdy)       return FWD_E_M;
    else if (w_live) return FWD_E_W;
    else             return FWD_E_REG;
  endfunction

  // D stage: every in-flight record against both D source operands
  hz_rec_t       sb_rec [3];
  logic [4:0]    d_reg  [2];
  logic [TW-1:0] d_tuse [2];
  logic          d_live  [3][2];
  logic          d_ready [3][2];
  logic          d_term  [3][2];

  assign sb_rec[0] = e_q;
  assign sb_rec[1] = m_q;
  assign sb_rec[2] = w_q;
  assign d_reg[0]  = rs_D;
  assign d_reg[1]  = rt_D;
  assign d_tuse[0] = tuse_rs_D;
  assign d_tuse[1] = tuse_rt_D;

  for (genvar s = 0; s < 3; s++) begin : g_d_stage
    for (genvar o = 0; o < 2; o++) begin : g_d_op
      hz_match u_match (
        .rec_i       (sb_rec[s]),
        .reg_i       (d_reg[o]),
        .tuse_i      (d_tuse[o]),
        .live_o      (d_live[s][o]),
        .ready_o     (d_ready[s][o]),
        .stall_term_o(d_term[s][o])
      );
    end
  end

  // E stage: M and W records against the operands held in E
  hz_rec_t    e_src [2];
  logic [4:0] e_reg [2];
  logic       e_live  [2][2];
  logic       e_ready [2][2];
  logic       e_term  [2][2];

  assign e_src[0] = m_q;
  assign e_src[1] = w_q;
  assign e_reg[0] = e_q.rs;
  assign e_reg[1] = e_q.rt;

  for (genvar s = 0; s < 2; s++) begin : g_e_stage
    for (genvar o = 0; o < 2; o++) begin : g_e_op
      hz_match u_match (
        .rec_i       (e_src[s]),
        .reg_i       (e_reg[o]),
        .tuse_i      (TUSE_NONE),
        .live_o      (e_live[s][o]),
        .ready_o     (e_ready[s][o]),
        .stall_term_o(e_term[s][o])
      );
    end
  end

  // M stage: store data can only be late by the W result
  logic m_live, m_ready, m_term;

  hz_match u_m_match (
    .rec_i       (w_q),
    .reg_i       (m_q.rt),
    .tuse_i      (TUSE_NONE),
    .live_o      (m_live),
    .ready_o     (m_ready),
    .stall_term_o(m_term)
  );

  logic unused_match;
  assign unused_match = ^{d_live[0][0], d_live[0][1], d_live[1][0], d_live[1][1],
                          d_ready[2][0], d_ready[2][1], d_term[2][0], d_term[2][1],
                          e_live[0][0], e_live[0][1], e_ready[1][0], e_ready[1][1],
                          e_term[0][0], e_term[0][1], e_term[1][0], e_term[1][1],
                          m_ready, m_term};

  assign stall    = d_term[0][0] | d_term[1][0] | d_term[0][1] | d_term[1][1];
  assign fwd_rs_D = d_sel(d_ready[0][0], d_ready[1][0], d_live[2][0]);
  assign fwd_rt_D = d_sel(d_ready[0][1], d_ready[1][1], d_live[2][1]);
  assign fwd_rs_E = e_sel(e_ready[0][0], e_live[1][0]);
  assign fwd_rt_E = e_sel(e_ready[0][1], e_live[1][1]);
  assign fwd_rt_M = m_live;
  assign stall_cnt = cnt_q;

  always_comb begin
    e_d = HZ_BUBBLE;
    if (!stall) begin
      e_d = '{rs: rs_D, rt: rt_D, a3: a3_D, we: we_D, tnew: tnew_D};
    end
    m_d      = e_q;
    m_d.tnew = sat_dec(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = '0;
    cnt_d    = stall ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Scoreboard advance: D -> E -> M -> W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q   <= HZ_BUBBLE;
      m_q   <= HZ_BUBBLE;
      w_q   <= HZ_BUBBLE;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle vector table with a queue of
// expected outputs, plus hand-written reset and stall-counter sequences.
module tb_hazard_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, a3_D;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_D;
  logic        we_D;
  logic        stall;
  logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic        fwd_rt_M;
  logic [31:0] stall_cnt;

  hazard_ctrl #(.TW(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_D(a3_D), .we_D(we_D), .tnew_D(tnew_D),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tr, tt;
    logic [4:0] a3;
    logic       we;
    logic [1:0] tn;
    logic       st;
    logic [1:0] fsd, ftd, fse, fte;
    logic       ftm;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int rs, rt, tr, tt, a3, we, tn,
                              input int st, fsd, ftd, fse, fte, ftm);
    vec_t r;
    r.rs = 5'(rs);  r.rt = 5'(rt);  r.tr = 2'(tr);  r.tt = 2'(tt);
    r.a3 = 5'(a3);  r.we = 1'(we);  r.tn = 2'(tn);
    r.st = 1'(st);  r.fsd = 2'(fsd); r.ftd = 2'(ftd);
    r.fse = 2'(fse); r.fte = 2'(fte); r.ftm = 1'(ftm);
    return r;
  endfunction

  function automatic vec_t nop(input int st, fsd, ftd, fse, fte, ftm);
    return mk(0, 0, 3, 3, 0, 0, 0, st, fsd, ftd, fse, fte, ftm);
  endfunction

  task automatic check(input string nm, input int row, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, row, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    rs_D = v.rs; rt_D = v.rt; tuse_rs_D = v.tr; tuse_rt_D = v.tt;
    a3_D = v.a3; we_D = v.we; tnew_D = v.tn;
  endtask

  task automatic check_outs(input int row, input vec_t e);
    check("stall",    row, 32'(stall),    32'(e.st));
    check("fwd_rs_D", row, 32'(fwd_rs_D), 32'(e.fsd));
    check("fwd_rt_D", row, 32'(fwd_rt_D), 32'(e.ftd));
    check("fwd_rs_E", row, 32'(fwd_rs_E), 32'(e.fse));
    check("fwd_rt_E", row, 32'(fwd_rt_E), 32'(e.fte));
    check("fwd_rt_M", row, 32'(fwd_rt_M), 32'(e.ftm));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    // lw $8 -> add $9,$8,$1 : one stall, then E takes $8 from W
    tbl.push_back(mk(29, 0, 1, 3, 8, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 8, 1, 1, 1, 9, 1, TNEW_ALU,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 8, 1, 1, 1, 9, 1, TNEW_ALU,  0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 2, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    // lw $8 -> beq $8,$0 : two stalls, then D takes $8 from W
    tbl.push_back(mk(29, 0, 1, 3, 8, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 8, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 8, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 8, 0, 0, 0, 0, 0, 0,         0, 3, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    // addu $3 -> subu $4,$3,$3 : no stall, both E operands from M, then store path
    tbl.push_back(mk( 1, 2, 1, 1, 3, 1, TNEW_ALU,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 3, 3, 1, 1, 4, 1, TNEW_ALU,  0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 1, 1, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    // jal -> jr $31 : forwarded straight from E
    tbl.push_back(mk( 0, 0, 3, 3, 31, 1, TNEW_LINK, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(31, 0, 0, 3, 0, 0, 0,          0, 1, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 1, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    // writes to $0 never create hazards
    tbl.push_back(mk(29, 0, 1, 3, 0, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 0, 0, 1, 1, 5, 1, TNEW_ALU,  0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    // two producers of $7 in flight: nearest stage wins
    tbl.push_back(mk( 0, 0, 3, 3, 7, 1, TNEW_LINK, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 0, 0, 3, 3, 7, 1, TNEW_LINK, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 7, 7, 0, 0, 0, 0, 0,         0, 1, 1, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 1, 1, 0));
    tbl.push_back(mk( 7, 7, 0, 0, 0, 0, 0,         0, 3, 3, 0, 0, 1));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    // $6 pending in both E and M: stall while either is late, then M beats W
    tbl.push_back(mk(29, 0, 1, 3, 6, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 0, 0, 3, 3, 6, 1, TNEW_ALU,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 6, 0, 0, 3, 0, 0, 0,         1, 0, 0, 0, 0, 0));
    tbl.push_back(mk( 6, 0, 0, 3, 0, 0, 0,         0, 2, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 2, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0, 0));

    reset = 1'b1;
    drive(nop(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    check_outs(-1, nop(0, 0, 0, 0, 0, 0));
    check("stall_cnt_reset", -1, stall_cnt, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard row %0d: got empty queue want entry", i);
      end else begin
        e = exp_q.pop_front();
        check_outs(i, e);
      end
    end

    @(posedge clk);
    #1;
    drive(nop(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("stall_cnt_total", 100, stall_cnt, 32'd4);

    // Stall in progress, then asynchronous reset in the middle of a cycle
    @(posedge clk);
    #1;
    drive(mk(29, 0, 1, 3, 8, 1, TNEW_LOAD, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    drive(mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("stall_pre_reset", 101, 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("stall_held", 102, 32'(stall), 32'd1);
    check("stall_cnt_pre_reset", 102, stall_cnt, 32'd5);
    #1;
    reset = 1'b1;
    #1;
    check_outs(103, nop(0, 0, 0, 0, 0, 0));
    check("stall_cnt_async_reset", 103, stall_cnt, 32'd0);
    #1;
    reset = 1'b0;
    drive(mk(1, 2, 1, 1, 3, 1, TNEW_ALU, 0, 0, 0, 0, 0, 0));
    #1;
    check_outs(104, nop(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("stall_after_accept", 105, 32'(stall), 32'd0);
    check("stall_cnt_after_accept", 105, stall_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
